// File: rtl/fifo_share_ctrl_pkg.sv
// Purpose: shared constants for the FIFO share controller and the buffer it fronts.
// Latency: n/a (constants and elaboration helpers only).
// Backpressure: n/a.
package fifo_share_ctrl_pkg;

  // These must agree with the buffer's width/depth defines.
  localparam int FSC_NUM_REQ = 4;
  localparam int FSC_DATA_W  = 32;
  localparam int FSC_DEPTH   = 7;
  localparam int FSC_CNT_W   = 3;

  // Index width for a one-hot vector of n bits (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_share_ctrl_if.sv
// Purpose: bundles writer/reader handshakes and the buffer-side strobes of the share controller.
// Latency: n/a (wiring only).
// Backpressure: grants and read gating are driven by the controller (slave side).
interface fifo_share_ctrl_if
  import fifo_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ = FSC_NUM_REQ,
  parameter int DATA_W  = FSC_DATA_W,
  parameter int CNT_W   = FSC_CNT_W
);
  logic [NUM_REQ-1:0]        wr_req;
  logic [NUM_REQ*DATA_W-1:0] wr_data;
  logic [NUM_REQ-1:0]        wr_grant;
  logic                      rd_req;
  logic                      rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      flush;
  logic                      full;
  logic                      empty;
  logic [CNT_W-1:0]          level;
  logic                      fifo_rst;
  logic                      fifo_enable_write;
  logic                      fifo_enable_read;
  logic [DATA_W-1:0]         fifo_value_to_write;
  logic [DATA_W-1:0]         fifo_value_to_read;

  // Environment side: writers, reader, flush source and the buffer itself.
  modport master (
    output wr_req, wr_data, rd_req, flush, fifo_value_to_read,
    input  wr_grant, rd_valid, rd_data, full, empty, level,
           fifo_rst, fifo_enable_write, fifo_enable_read, fifo_value_to_write
  );

  // Controller side.
  modport slave (
    input  wr_req, wr_data, rd_req, flush, fifo_value_to_read,
    output wr_grant, rd_valid, rd_data, full, empty, level,
           fifo_rst, fifo_enable_write, fifo_enable_read, fifo_value_to_write
  );
endinterface

// File: rtl/fifo_share_ctrl_rr_arbiter.sv
// Purpose: round-robin arbiter, one-hot grant searching from the last winner + 1.
// Latency: grant is combinational in the request cycle; pointer moves at the next edge.
// Backpressure: enable_i low suppresses all grants and freezes the pointer.
module rr_arbiter
  import fifo_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ = FSC_NUM_REQ
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic                        enable_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [idx_w(NUM_REQ)-1:0]   grant_idx_o
);
  localparam int IDX_W = idx_w(NUM_REQ);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Pick the first requester after the last winner, wrapping around.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (enable_i && !found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  // Pointer follows the winner; holds when nobody is granted.
  always_comb begin
    ptr_d = found ? grant_idx_o : ptr_q;
  end

  // Reset to the last index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= IDX_W'(NUM_REQ - 1);
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fifo_share_ctrl.sv
// Purpose: shares one flagless FIFO among NUM_REQ writers and one reader, tracking occupancy.
// Latency: write grant same cycle; rd_valid one cycle after the read strobe.
// Backpressure: writes held off when full (unless paired with a read); reads gated when empty.
module fifo_share_ctrl
  import fifo_share_ctrl_pkg::*;
#(
  parameter int NUM_REQ = FSC_NUM_REQ,
  parameter int DATA_W  = FSC_DATA_W,
  parameter int DEPTH   = FSC_DEPTH,
  parameter int CNT_W   = FSC_CNT_W
) (
  input logic              clk,
  input logic              rst,
  fifo_share_ctrl_if.slave bus
);
  localparam int               IDX_W   = idx_w(NUM_REQ);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]   level_q, level_d;
  logic               rd_valid_q, rd_valid_d;
  logic               empty, full, rd_go, wr_ok, wr_go;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [DATA_W-1:0]  wr_value;

  assign empty = (level_q == '0);
  assign full  = (level_q == DEPTH_C);

  // rst gating keeps grants and strobes quiet while the buffer is held in reset.
  assign rd_go = rst & bus.rd_req & ~empty & ~bus.flush;
  // A full buffer still accepts a word when a read shifts it out in the same cycle.
  assign wr_ok = rst & ~bus.flush & (~full | rd_go);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i       (clk),
    .rst_ni      (rst),
    .req_i       (bus.wr_req),
    .enable_i    (wr_ok),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign wr_go = |grant;

  // Steer the granted requester's slice onto the shared write path, zero when idle.
  always_comb begin
    wr_value = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr_go && grant_idx == IDX_W'(k)) wr_value = bus.wr_data[k*DATA_W +: DATA_W];
    end
  end

  // Occupancy next state: flush wins, simultaneous read and write cancel out.
  always_comb begin
    level_d    = level_q;
    rd_valid_d = rd_go;
    if (bus.flush)           level_d = '0;
    else if (wr_go && !rd_go) level_d = level_q + CNT_W'(1);
    else if (rd_go && !wr_go) level_d = level_q - CNT_W'(1);
  end

  // Occupancy and read-valid registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.wr_grant            = grant;
  assign bus.fifo_enable_write   = wr_go;
  assign bus.fifo_enable_read    = rd_go;
  assign bus.fifo_value_to_write = wr_value;
  assign bus.fifo_rst            = ~rst | bus.flush;
  assign bus.rd_valid            = rd_valid_q;
  assign bus.rd_data             = bus.fifo_value_to_read;
  assign bus.full                = full;
  assign bus.empty               = empty;
  assign bus.level               = level_q;

  a_level_bound: assert property (@(posedge clk) disable iff (!rst) level_q <= DEPTH_C);
  a_no_read_empty: assert property (@(posedge clk) disable iff (!rst) !(rd_go && empty));
endmodule

// File: tb/tb_fifo_share_ctrl.sv
module tb_fifo_share_ctrl;
  import fifo_share_ctrl_pkg::*;

  localparam int NR    = FSC_NUM_REQ;
  localparam int DW    = FSC_DATA_W;
  localparam int DEPTH = FSC_DEPTH;
  localparam int CW    = FSC_CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_share_ctrl_if #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW)) bus ();

  fifo_share_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus variables
  logic [NR-1:0]    req;
  logic [DW-1:0]    wdat [NR];
  logic             rdreq;
  logic             fl;
  logic [NR*DW-1:0] flat;

  always_comb begin
    flat = '0;
    for (int k = 0; k < NR; k++) flat[k*DW +: DW] = wdat[k];
  end
  assign bus.wr_req  = req;
  assign bus.wr_data = flat;
  assign bus.rd_req  = rdreq;
  assign bus.flush   = fl;

  // Behavioural stand-in for the shared buffer: registered read data, no flags.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] fifo_rd_q = '0;
  always @(posedge clk) begin
    if (bus.fifo_rst) fq.delete();
    else begin
      if (bus.fifo_enable_read && fq.size() > 0) fifo_rd_q <= fq.pop_front();
      if (bus.fifo_enable_write) fq.push_back(bus.fifo_value_to_write);
    end
  end
  assign bus.fifo_value_to_read = fifo_rd_q;

  // Reference model of the controller
  int            m_level;
  int            m_ptr;
  bit            m_rdv;
  logic [DW-1:0] m_rdd;
  logic [DW-1:0] m_sb[$];
  logic [NR-1:0] last_grant;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0;
    m_ptr   = NR - 1;
    m_rdv   = 1'b0;
    m_sb.delete();
  endtask

  // One clock: predict, check combinational/registered outputs, advance model at the edge.
  task automatic cycle();
    logic [NR-1:0] eg;
    logic [DW-1:0] ewd;
    int            gi;
    bit            erd;
    bit            ewok;
    if (!rst) model_reset();
    erd  = rst && rdreq && (m_level > 0) && !fl;
    ewok = rst && !fl && ((m_level < DEPTH) || erd);
    eg   = '0;
    ewd  = '0;
    gi   = -1;
    if (ewok) begin
      for (int i = 1; i <= NR; i++) begin
        int k;
        k = (m_ptr + i) % NR;
        if (gi < 0 && req[k]) gi = k;
      end
    end
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ewd    = wdat[gi];
    end
    #1;
    chk("fifo_rst", bus.fifo_rst, !rst || fl);
    chk("wr_grant", bus.wr_grant, eg);
    chk("en_write", bus.fifo_enable_write, gi >= 0);
    chk("wr_value", bus.fifo_value_to_write, ewd);
    chk("en_read", bus.fifo_enable_read, erd);
    chk("level", bus.level, m_level);
    chk("full", bus.full, m_level == DEPTH);
    chk("empty", bus.empty, m_level == 0);
    chk("rd_valid", bus.rd_valid, m_rdv);
    if (m_rdv) chk("rd_data", bus.rd_data, m_rdd);
    last_grant = eg;
    @(posedge clk);
    if (!rst) model_reset();
    else if (fl) begin
      m_level = 0;
      m_rdv   = 1'b0;
      m_sb.delete();
    end else begin
      if (erd) begin
        m_rdd = m_sb.pop_front();
        m_rdv = 1'b1;
      end else m_rdv = 1'b0;
      if (gi >= 0) begin
        m_sb.push_back(ewd);
        m_ptr = gi;
      end
      m_level = m_level + int'(gi >= 0) - int'(erd);
    end
    @(negedge clk);
  endtask

  initial begin
    int rd_pct;
    req   = '1;
    rdreq = 1'b0;
    fl    = 1'b0;
    for (int k = 0; k < NR; k++) wdat[k] = 32'hA0 + k;
    model_reset();
    @(negedge clk);

    // Reset held with all requests up
    repeat (3) cycle();
    rst = 1'b1;

    // Round-robin fill: grants 0,1,2,3,0,1,2 then stall on full
    repeat (8) cycle();
    chk("fill_level", bus.level, 7);
    chk("fill_full", bus.full, 1);

    // Drain
    req   = '0;
    rdreq = 1'b1;
    repeat (8) cycle();
    chk("drain_empty", bus.empty, 1);

    // Refill, then read and write together while full
    rdreq = 1'b0;
    req   = '1;
    repeat (7) cycle();
    req     = 4'b0010;
    wdat[1] = 32'h55;
    rdreq   = 1'b1;
    cycle();
    chk("fullrw_level", bus.level, 7);
    req = '0;
    repeat (8) cycle();
    chk("fullrw_last", bus.rd_data, 32'h55);

    // Empty with simultaneous read and write
    req     = 4'b0100;
    wdat[2] = $urandom;
    rdreq   = 1'b1;
    cycle();
    req   = '0;
    rdreq = 1'b0;
    cycle();
    chk("emptyrw_level", bus.level, 1);

    // Flush mid-stream with a read still in flight
    req = '1;
    repeat (3) cycle();
    rdreq = 1'b1;
    cycle();
    fl    = 1'b1;
    req   = 4'b0001;
    cycle();
    fl    = 1'b0;
    req   = '0;
    rdreq = 1'b0;
    cycle();
    chk("flush_level", bus.level, 0);

    // Randomised traffic with occasional flush and asynchronous reset
    rd_pct = 45;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) rd_pct = (rd_pct == 25) ? 70 : 25;
      for (int k = 0; k < NR; k++) begin
        if (last_grant[k]) begin
          if ($urandom_range(1, 0) == 1) req[k] = 1'b0;
          else wdat[k] = $urandom;
        end else if (!req[k] && $urandom_range(99, 0) < 40) begin
          req[k]  = 1'b1;
          wdat[k] = $urandom;
        end
      end
      rdreq = ($urandom_range(99, 0) < rd_pct);
      fl    = ($urandom_range(99, 0) < 3);
      rst   = !($urandom_range(199, 0) < 2);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
